// File: rtl/pipe_ctrl_unit.sv
// Pipeline control unit for the 5-stage core.
// Decodes the ID opcode into a 7-bit control bundle and carries it through the
// ID/EX, EX/MEM and MEM/WB control registers. It also detects load-use hazards,
// flushes IF/ID on EX-resolved jumps and taken branches, and keeps saturating
// stall/flush performance counters.
// Control bundle bit map: [0] reg_write [1] alu_src [2] mem_read [3] mem_write
//                         [4] mem_to_reg [5] branch [6] jump
module pipe_ctrl_unit #(
    parameter int REG_AW     = 5,
    parameter bit ENABLE_EXT = 1'b1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [6:0]        id_opcode,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              ex_branch_taken,
    input  logic              stall_ext,
    output logic [6:0]        ex_ctrl,
    output logic [6:0]        mem_ctrl,
    output logic [6:0]        wb_ctrl,
    output logic [REG_AW-1:0] ex_rd,
    output logic [REG_AW-1:0] mem_rd,
    output logic [REG_AW-1:0] wb_rd,
    output logic              ex_valid,
    output logic              mem_valid,
    output logic              wb_valid,
    output logic              wb_illegal,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              load_use_stall,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [7:0] DEC_ILLEGAL = 8'h80;

    // Returns {illegal, ctrl[6:0]} for an opcode; extended opcodes are
    // illegal in the legacy subset.
    function automatic logic [7:0] decode_f(input logic [6:0] op);
        logic [7:0] d;
        case (op)
            OP_RTYPE:  d = 8'h01;
            OP_IALU:   d = 8'h03;
            OP_JAL:    d = 8'h41;
            OP_LOAD:   d = ENABLE_EXT ? 8'h17 : DEC_ILLEGAL;
            OP_STORE:  d = ENABLE_EXT ? 8'h0A : DEC_ILLEGAL;
            OP_BRANCH: d = ENABLE_EXT ? 8'h20 : DEC_ILLEGAL;
            OP_JALR:   d = ENABLE_EXT ? 8'h43 : DEC_ILLEGAL;
            OP_LUI:    d = ENABLE_EXT ? 8'h03 : DEC_ILLEGAL;
            default:   d = DEC_ILLEGAL;
        endcase
        return d;
    endfunction

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc_f(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    logic [7:0]        id_dec_s;
    logic [6:0]        id_ctrl_s;
    logic              id_ill_s;
    logic [REG_AW-1:0] id_rd_s;
    logic              uses_rs1_s;
    logic              uses_rs2_s;
    logic              load_use_s;
    logic              redirect_s;
    logic              hold_s;
    logic              bubble_s;
    logic              inc_stall_s;
    logic              inc_flush_s;
    logic              pc_write_s;
    logic              if_id_write_s;
    logic              if_id_flush_s;
    logic              load_use_stall_s;

    logic [6:0]        ex_ctrl_r, mem_ctrl_r, wb_ctrl_r;
    logic [REG_AW-1:0] ex_rd_r, mem_rd_r, wb_rd_r;
    logic              ex_valid_r, mem_valid_r, wb_valid_r;
    logic              ex_ill_r, mem_ill_r, wb_ill_r;
    logic [CNT_W-1:0]  stall_cnt_r, flush_cnt_r;

    // Decode the ID instruction; a bubble yields a null bundle and never flags illegal.
    always_comb begin
        id_dec_s = decode_f(id_opcode);
        if (id_valid) begin
            id_ctrl_s = id_dec_s[6:0];
            id_ill_s  = id_dec_s[7];
            id_rd_s   = id_rd;
        end else begin
            id_ctrl_s = 7'b0000000;
            id_ill_s  = 1'b0;
            id_rd_s   = {REG_AW{1'b0}};
        end
    end

    // Load-use detection against the load in EX and EX-resolved redirect.
    always_comb begin
        uses_rs1_s = (id_opcode != OP_JAL) && (id_opcode != OP_LUI);
        uses_rs2_s = (id_opcode == OP_RTYPE) || (id_opcode == OP_STORE) ||
                     (id_opcode == OP_BRANCH);
        load_use_s = ex_valid_r && ex_ctrl_r[2] && (ex_rd_r != {REG_AW{1'b0}}) &&
                     id_valid &&
                     (((ex_rd_r == id_rs1) && uses_rs1_s) ||
                      ((ex_rd_r == id_rs2) && uses_rs2_s));
        redirect_s = ex_valid_r && (ex_ctrl_r[6] || (ex_ctrl_r[5] && ex_branch_taken));
    end

    // Per-cycle priority: reset, external hold, redirect, load-use, advance.
    always_comb begin
        pc_write_s       = 1'b1;
        if_id_write_s    = 1'b1;
        if_id_flush_s    = 1'b0;
        load_use_stall_s = 1'b0;
        hold_s           = 1'b0;
        bubble_s         = 1'b0;
        inc_stall_s      = 1'b0;
        inc_flush_s      = 1'b0;
        if (rst) begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
        end else if (stall_ext) begin
            pc_write_s    = 1'b0;
            if_id_write_s = 1'b0;
            hold_s        = 1'b1;
        end else if (redirect_s) begin
            if_id_flush_s = 1'b1;
            bubble_s      = 1'b1;
            inc_flush_s   = 1'b1;
        end else if (load_use_s) begin
            pc_write_s       = 1'b0;
            if_id_write_s    = 1'b0;
            load_use_stall_s = 1'b1;
            bubble_s         = 1'b1;
            inc_stall_s      = 1'b1;
        end else begin
            pc_write_s    = 1'b1;
            if_id_write_s = 1'b1;
        end
    end

    // Stage control registers and perf counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_ctrl_r   <= 7'b0000000;
            mem_ctrl_r  <= 7'b0000000;
            wb_ctrl_r   <= 7'b0000000;
            ex_rd_r     <= {REG_AW{1'b0}};
            mem_rd_r    <= {REG_AW{1'b0}};
            wb_rd_r     <= {REG_AW{1'b0}};
            ex_valid_r  <= 1'b0;
            mem_valid_r <= 1'b0;
            wb_valid_r  <= 1'b0;
            ex_ill_r    <= 1'b0;
            mem_ill_r   <= 1'b0;
            wb_ill_r    <= 1'b0;
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else if (!hold_s) begin
            if (bubble_s) begin
                ex_ctrl_r  <= 7'b0000000;
                ex_rd_r    <= {REG_AW{1'b0}};
                ex_valid_r <= 1'b0;
                ex_ill_r   <= 1'b0;
            end else begin
                ex_ctrl_r  <= id_ctrl_s;
                ex_rd_r    <= id_rd_s;
                ex_valid_r <= id_valid;
                ex_ill_r   <= id_ill_s;
            end
            mem_ctrl_r  <= ex_ctrl_r;
            mem_rd_r    <= ex_rd_r;
            mem_valid_r <= ex_valid_r;
            mem_ill_r   <= ex_ill_r;
            wb_ctrl_r   <= mem_ctrl_r;
            wb_rd_r     <= mem_rd_r;
            wb_valid_r  <= mem_valid_r;
            wb_ill_r    <= mem_ill_r;
            if (inc_stall_s) begin
                stall_cnt_r <= sat_inc_f(stall_cnt_r);
            end
            if (inc_flush_s) begin
                flush_cnt_r <= sat_inc_f(flush_cnt_r);
            end
        end
    end

    assign ex_ctrl        = ex_ctrl_r;
    assign mem_ctrl       = mem_ctrl_r;
    assign wb_ctrl        = wb_ctrl_r;
    assign ex_rd          = ex_rd_r;
    assign mem_rd         = mem_rd_r;
    assign wb_rd          = wb_rd_r;
    assign ex_valid       = ex_valid_r;
    assign mem_valid      = mem_valid_r;
    assign wb_valid       = wb_valid_r;
    assign wb_illegal     = wb_ill_r;
    assign stall_cnt      = stall_cnt_r;
    assign flush_cnt      = flush_cnt_r;
    assign pc_write       = pc_write_s;
    assign if_id_write    = if_id_write_s;
    assign if_id_flush    = if_id_flush_s;
    assign load_use_stall = load_use_stall_s;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Self-checking bench for pipe_ctrl_unit: a directed vector table on the full
// decoder plus hand-written sequences on a legacy-subset, 2-bit-counter instance.
module tb_pipe_ctrl_unit;

    localparam logic [6:0] OR = 7'h33;
    localparam logic [6:0] OI = 7'h13;
    localparam logic [6:0] OJ = 7'h6F;
    localparam logic [6:0] OL = 7'h03;
    localparam logic [6:0] OS = 7'h23;
    localparam logic [6:0] OB = 7'h63;
    localparam logic [6:0] OU = 7'h37;
    localparam logic [6:0] ON = 7'h00;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [6:0] id_opcode;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       ex_branch_taken;
    logic       stall_ext;

    logic [6:0]  m_ex_ctrl, m_mem_ctrl, m_wb_ctrl;
    logic [4:0]  m_ex_rd, m_mem_rd, m_wb_rd;
    logic        m_ex_valid, m_mem_valid, m_wb_valid, m_wb_illegal;
    logic        m_pc_write, m_if_id_write, m_if_id_flush, m_load_use_stall;
    logic [15:0] m_stall_cnt, m_flush_cnt;

    logic [6:0]  e_ex_ctrl, e_mem_ctrl, e_wb_ctrl;
    logic [4:0]  e_ex_rd, e_mem_rd, e_wb_rd;
    logic        e_ex_valid, e_mem_valid, e_wb_valid, e_wb_illegal;
    logic        e_pc_write, e_if_id_write, e_if_id_flush, e_load_use_stall;
    logic [1:0]  e_stall_cnt, e_flush_cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_EXT(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
        .ex_ctrl(m_ex_ctrl), .mem_ctrl(m_mem_ctrl), .wb_ctrl(m_wb_ctrl),
        .ex_rd(m_ex_rd), .mem_rd(m_mem_rd), .wb_rd(m_wb_rd),
        .ex_valid(m_ex_valid), .mem_valid(m_mem_valid), .wb_valid(m_wb_valid),
        .wb_illegal(m_wb_illegal), .pc_write(m_pc_write),
        .if_id_write(m_if_id_write), .if_id_flush(m_if_id_flush),
        .load_use_stall(m_load_use_stall),
        .stall_cnt(m_stall_cnt), .flush_cnt(m_flush_cnt)
    );

    pipe_ctrl_unit #(.REG_AW(5), .ENABLE_EXT(1'b0), .CNT_W(2)) dut_legacy (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
        .ex_ctrl(e_ex_ctrl), .mem_ctrl(e_mem_ctrl), .wb_ctrl(e_wb_ctrl),
        .ex_rd(e_ex_rd), .mem_rd(e_mem_rd), .wb_rd(e_wb_rd),
        .ex_valid(e_ex_valid), .mem_valid(e_mem_valid), .wb_valid(e_wb_valid),
        .wb_illegal(e_wb_illegal), .pc_write(e_pc_write),
        .if_id_write(e_if_id_write), .if_id_flush(e_if_id_flush),
        .load_use_stall(e_load_use_stall),
        .stall_cnt(e_stall_cnt), .flush_cnt(e_flush_cnt)
    );

    // One cycle of stimulus; cmb = expected {pc_write, if_id_write, if_id_flush,
    // load_use_stall} before the edge (cl gates the load_use_stall compare),
    // the rest is expected after the edge.
    typedef struct {
        logic        r, v;
        logic [6:0]  op;
        logic [4:0]  a, b, d;
        logic        tk, se;
        logic [3:0]  cmb;
        logic        cl;
        logic [6:0]  ex;
        logic        ev;
        logic [6:0]  wb;
        logic [15:0] sc, fc;
    } vec_t;

    vec_t vt[30];

    function automatic vec_t mk(input logic r, input logic v, input logic [6:0] op,
                                input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input logic tk, input logic se, input logic [3:0] cmb,
                                input logic cl, input logic [6:0] ex, input logic ev,
                                input logic [6:0] wb, input logic [15:0] sc,
                                input logic [15:0] fc);
        vec_t t;
        t.r = r; t.v = v; t.op = op; t.a = a; t.b = b; t.d = d; t.tk = tk; t.se = se;
        t.cmb = cmb; t.cl = cl; t.ex = ex; t.ev = ev; t.wb = wb; t.sc = sc; t.fc = fc;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic apply(input logic r, input logic v, input logic [6:0] op,
                         input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic tk, input logic se);
        rst = r; id_valid = v; id_opcode = op; id_rs1 = a; id_rs2 = b; id_rd = d;
        ex_branch_taken = tk; stall_ext = se;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        apply(1'b1, 1'b0, ON, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

        //            r     v     op  rs1    rs2    rd      tk    se    cmb      cl    ex     ev    wb     sc     fc
        vt[0]  = mk(1'b1, 1'b0, ON, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h00, 1'b0, 7'h00, 16'd0, 16'd0);
        vt[1]  = mk(1'b1, 1'b1, OR, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h00, 1'b0, 7'h00, 16'd0, 16'd0);
        vt[2]  = mk(1'b0, 1'b1, OR, 5'd1,  5'd2,  5'd3,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h01, 1'b1, 7'h00, 16'd0, 16'd0);
        vt[3]  = mk(1'b0, 1'b1, OI, 5'd1,  5'd0,  5'd4,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h03, 1'b1, 7'h00, 16'd0, 16'd0);
        vt[4]  = mk(1'b0, 1'b1, OJ, 5'd0,  5'd0,  5'd6,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h41, 1'b1, 7'h01, 16'd0, 16'd0);
        vt[5]  = mk(1'b0, 1'b1, OR, 5'd1,  5'd2,  5'd7,  1'b0, 1'b0, 4'b1110, 1'b1, 7'h00, 1'b0, 7'h03, 16'd0, 16'd1);
        vt[6]  = mk(1'b0, 1'b0, ON, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h00, 1'b0, 7'h41, 16'd0, 16'd1);
        vt[7]  = mk(1'b0, 1'b1, OL, 5'd1,  5'd0,  5'd5,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h17, 1'b1, 7'h00, 16'd0, 16'd1);
        vt[8]  = mk(1'b0, 1'b1, OR, 5'd1,  5'd5,  5'd8,  1'b0, 1'b0, 4'b0001, 1'b1, 7'h00, 1'b0, 7'h00, 16'd1, 16'd1);
        vt[9]  = mk(1'b0, 1'b1, OR, 5'd1,  5'd5,  5'd8,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h01, 1'b1, 7'h17, 16'd1, 16'd1);
        vt[10] = mk(1'b0, 1'b1, OL, 5'd2,  5'd0,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h17, 1'b1, 7'h00, 16'd1, 16'd1);
        vt[11] = mk(1'b0, 1'b1, OR, 5'd0,  5'd0,  5'd9,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h01, 1'b1, 7'h01, 16'd1, 16'd1);
        vt[12] = mk(1'b0, 1'b1, OL, 5'd1,  5'd0,  5'd6,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h17, 1'b1, 7'h17, 16'd1, 16'd1);
        vt[13] = mk(1'b0, 1'b1, OU, 5'd6,  5'd0,  5'd10, 1'b0, 1'b0, 4'b1100, 1'b1, 7'h03, 1'b1, 7'h01, 16'd1, 16'd1);
        vt[14] = mk(1'b0, 1'b1, OL, 5'd1,  5'd0,  5'd6,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h17, 1'b1, 7'h17, 16'd1, 16'd1);
        vt[15] = mk(1'b0, 1'b1, OS, 5'd1,  5'd6,  5'd0,  1'b0, 1'b0, 4'b0001, 1'b1, 7'h00, 1'b0, 7'h03, 16'd2, 16'd1);
        vt[16] = mk(1'b0, 1'b1, OS, 5'd1,  5'd6,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h0A, 1'b1, 7'h17, 16'd2, 16'd1);
        vt[17] = mk(1'b0, 1'b1, OL, 5'd1,  5'd0,  5'd7,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h17, 1'b1, 7'h00, 16'd2, 16'd1);
        vt[18] = mk(1'b0, 1'b0, OR, 5'd7,  5'd7,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h00, 1'b0, 7'h0A, 16'd2, 16'd1);
        vt[19] = mk(1'b0, 1'b1, OB, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h20, 1'b1, 7'h17, 16'd2, 16'd1);
        vt[20] = mk(1'b0, 1'b1, OI, 5'd3,  5'd0,  5'd11, 1'b0, 1'b0, 4'b1100, 1'b1, 7'h03, 1'b1, 7'h00, 16'd2, 16'd1);
        vt[21] = mk(1'b0, 1'b1, OB, 5'd1,  5'd2,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h20, 1'b1, 7'h20, 16'd2, 16'd1);
        vt[22] = mk(1'b0, 1'b1, OR, 5'd1,  5'd2,  5'd12, 1'b1, 1'b0, 4'b1110, 1'b1, 7'h00, 1'b0, 7'h03, 16'd2, 16'd2);
        vt[23] = mk(1'b0, 1'b0, ON, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h00, 1'b0, 7'h20, 16'd2, 16'd2);
        vt[24] = mk(1'b0, 1'b1, OL, 5'd1,  5'd0,  5'd5,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h17, 1'b1, 7'h00, 16'd2, 16'd2);
        vt[25] = mk(1'b0, 1'b1, OR, 5'd1,  5'd5,  5'd8,  1'b0, 1'b1, 4'b0000, 1'b0, 7'h17, 1'b1, 7'h00, 16'd2, 16'd2);
        vt[26] = mk(1'b0, 1'b1, OR, 5'd1,  5'd5,  5'd8,  1'b0, 1'b1, 4'b0000, 1'b0, 7'h17, 1'b1, 7'h00, 16'd2, 16'd2);
        vt[27] = mk(1'b0, 1'b1, OR, 5'd1,  5'd5,  5'd8,  1'b0, 1'b1, 4'b0000, 1'b0, 7'h17, 1'b1, 7'h00, 16'd2, 16'd2);
        vt[28] = mk(1'b0, 1'b1, OR, 5'd1,  5'd5,  5'd8,  1'b0, 1'b0, 4'b0001, 1'b1, 7'h00, 1'b0, 7'h00, 16'd3, 16'd2);
        vt[29] = mk(1'b0, 1'b1, OR, 5'd1,  5'd5,  5'd8,  1'b0, 1'b0, 4'b1100, 1'b1, 7'h01, 1'b1, 7'h17, 16'd3, 16'd2);

        for (int i = 0; i < 30; i++) begin
            apply(vt[i].r, vt[i].v, vt[i].op, vt[i].a, vt[i].b, vt[i].d, vt[i].tk, vt[i].se);
            #1;
            chk($sformatf("v%0d pc_write", i),    32'(m_pc_write),    32'(vt[i].cmb[3]));
            chk($sformatf("v%0d if_id_write", i), 32'(m_if_id_write), 32'(vt[i].cmb[2]));
            chk($sformatf("v%0d if_id_flush", i), 32'(m_if_id_flush), 32'(vt[i].cmb[1]));
            if (vt[i].cl) begin
                chk($sformatf("v%0d load_use_stall", i), 32'(m_load_use_stall), 32'(vt[i].cmb[0]));
            end
            tick();
            chk($sformatf("v%0d ex_ctrl", i),   32'(m_ex_ctrl),   32'(vt[i].ex));
            chk($sformatf("v%0d ex_valid", i),  32'(m_ex_valid),  32'(vt[i].ev));
            chk($sformatf("v%0d wb_ctrl", i),   32'(m_wb_ctrl),   32'(vt[i].wb));
            chk($sformatf("v%0d stall_cnt", i), 32'(m_stall_cnt), 32'(vt[i].sc));
            chk($sformatf("v%0d flush_cnt", i), 32'(m_flush_cnt), 32'(vt[i].fc));
        end

        // Legacy subset: load opcode is illegal, carries no mem_read, so no hazard.
        apply(1'b1, 1'b0, ON, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        apply(1'b0, 1'b1, OL, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
        tick();
        chk("leg ex_ctrl load", 32'(e_ex_ctrl), 32'h00);
        chk("leg ex_valid load", 32'(e_ex_valid), 32'd1);
        chk("ext ex_rd load", 32'(m_ex_rd), 32'd5);
        apply(1'b0, 1'b1, OR, 5'd1, 5'd5, 5'd8, 1'b0, 1'b0);
        #1;
        chk("leg load_use_stall", 32'(e_load_use_stall), 32'd0);
        chk("leg pc_write", 32'(e_pc_write), 32'd1);
        chk("ext load_use_stall", 32'(m_load_use_stall), 32'd1);
        tick();
        chk("leg ex_ctrl add", 32'(e_ex_ctrl), 32'h01);
        chk("leg wb_illegal early", 32'(e_wb_illegal), 32'd0);
        chk("ext mem_ctrl load", 32'(m_mem_ctrl), 32'h17);
        chk("ext mem_rd load", 32'(m_mem_rd), 32'd5);
        apply(1'b0, 1'b0, ON, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        chk("leg wb_illegal", 32'(e_wb_illegal), 32'd1);
        chk("leg wb_valid", 32'(e_wb_valid), 32'd1);
        chk("ext wb_illegal", 32'(m_wb_illegal), 32'd0);
        chk("ext wb_ctrl load", 32'(m_wb_ctrl), 32'h17);
        tick();
        chk("leg wb_illegal clears", 32'(e_wb_illegal), 32'd0);

        // Back-to-back jumps: every other one is flushed, giving five redirects.
        apply(1'b1, 1'b0, ON, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 10; k++) begin
            apply(1'b0, 1'b1, OJ, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
            tick();
        end
        chk("ext flush_cnt 5 jumps", 32'(m_flush_cnt), 32'd5);
        chk("leg flush_cnt saturates", 32'(e_flush_cnt), 32'd3);
        chk("leg stall_cnt", 32'(e_stall_cnt), 32'd0);
        apply(1'b0, 1'b1, OJ, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        tick();
        chk("ext ex_valid jal", 32'(m_ex_valid), 32'd1);
        // Reset while a redirect is pending in EX.
        apply(1'b1, 1'b1, OJ, 5'd0, 5'd0, 5'd1, 1'b0, 1'b0);
        #1;
        chk("rst pc_write", 32'(m_pc_write), 32'd1);
        chk("rst if_id_write", 32'(m_if_id_write), 32'd1);
        chk("rst if_id_flush", 32'(m_if_id_flush), 32'd0);
        tick();
        chk("rst ex_valid", 32'(m_ex_valid), 32'd0);
        chk("rst ex_ctrl", 32'(m_ex_ctrl), 32'h00);
        chk("rst mem_valid", 32'(m_mem_valid), 32'd0);
        chk("rst wb_ctrl", 32'(m_wb_ctrl), 32'h00);
        chk("rst wb_rd", 32'(m_wb_rd), 32'd0);
        chk("rst ext flush_cnt", 32'(m_flush_cnt), 32'd0);
        chk("rst leg flush_cnt", 32'(e_flush_cnt), 32'd0);
        apply(1'b0, 1'b0, ON, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1;
        chk("post-rst if_id_flush", 32'(m_if_id_flush), 32'd0);
        chk("post-rst pc_write", 32'(m_pc_write), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
